// File: rtl/parking_gate_controller.sv
// parking_gate_controller
//   Entry/exit barrier controller for a car park with separate university and
//   public spaces. Raw loop detectors are debounced, an entry FSM grants or
//   refuses entry based on badge class and vacancy, an exit FSM always opens,
//   and passage events are reported to the occupancy counter one per cycle
//   (entry wins a same-cycle collision, exit follows on the next cycle).
//
//   Optional build macro: GATE_TIMEOUT_EN -- adds an open-barrier timer per
//   lane; a barrier left open OPEN_TIMEOUT cycles without passage closes and
//   pulses o_timeout_err. Without the macro o_timeout_err is tied 0.
//
//   Parameters : DEBOUNCE_CYCLES  stable samples needed to move a debounced level
//                OPEN_TIMEOUT     open-barrier limit in cycles (timeout build only)
//   Inputs     : clk, reset (async, active-high)
//                i_entry_sensor, i_entry_badge, i_exit_sensor, i_exit_badge
//                i_uni_is_vacated_space, i_is_vacated_space
//   Outputs    : o_entry_barrier_open, o_exit_barrier_open
//                o_car_entered, o_is_uni_car_entered (one-cycle event + class)
//                o_car_exited,  o_is_uni_car_exited  (one-cycle event + class)
//                o_entry_denied, o_timeout_err       (one-cycle status)

// Debouncer: level follows the raw input once it has differed from the
// current level for N consecutive samples; any agreeing sample restarts the
// count. Edge pulses are valid for the cycle after the level moves.
module pgc_debounce #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    localparam int W = (N < 2) ? 1 : $clog2(N + 1);

    logic [W-1:0] r_cnt;
    logic         r_lvl;
    logic         r_lvl_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_lvl_d <= r_lvl;
            if (i_raw == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == W'(N - 1)) begin
                r_lvl <= i_raw;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_lvl & ~r_lvl_d;
    assign o_fall = ~r_lvl & r_lvl_d;
endmodule

module parking_gate_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPEN_TIMEOUT    = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_entry_sensor,
    input  logic i_entry_badge,
    input  logic i_exit_sensor,
    input  logic i_exit_badge,
    input  logic i_uni_is_vacated_space,
    input  logic i_is_vacated_space,
    output logic o_entry_barrier_open,
    output logic o_exit_barrier_open,
    output logic o_car_entered,
    output logic o_is_uni_car_entered,
    output logic o_car_exited,
    output logic o_is_uni_car_exited,
    output logic o_entry_denied,
    output logic o_timeout_err
);
    localparam logic [1:0] E_IDLE  = 2'd0;
    localparam logic [1:0] E_CHECK = 2'd1;
    localparam logic [1:0] E_OPEN  = 2'd2;
    localparam logic [1:0] E_DENY  = 2'd3;
    localparam logic [0:0] X_IDLE  = 1'b0;
    localparam logic [0:0] X_OPEN  = 1'b1;

    // Elaboration-time sanity check on the configuration.
    if (DEBOUNCE_CYCLES < 1 || OPEN_TIMEOUT < 1) begin : g_bad_param
        $error("parking_gate_controller: DEBOUNCE_CYCLES and OPEN_TIMEOUT must be >= 1");
    end

    // ---------------- debounced sensors ----------------
    logic w_e_lvl, w_e_rise, w_e_fall;
    logic w_x_lvl, w_x_rise, w_x_fall;

    pgc_debounce #(.N(DEBOUNCE_CYCLES)) u_db_entry (
        .clk(clk), .reset(reset), .i_raw(i_entry_sensor),
        .o_lvl(w_e_lvl), .o_rise(w_e_rise), .o_fall(w_e_fall)
    );

    pgc_debounce #(.N(DEBOUNCE_CYCLES)) u_db_exit (
        .clk(clk), .reset(reset), .i_raw(i_exit_sensor),
        .o_lvl(w_x_lvl), .o_rise(w_x_rise), .o_fall(w_x_fall)
    );

    logic [1:0] r_estate;
    logic [0:0] r_xstate;
    logic       r_euni;
    logic       r_xuni;
    logic       r_denied;

    // Passage requests: a falling edge while the barrier is open.
    logic w_e_req, w_x_req;
    assign w_e_req = (r_estate == E_OPEN) && w_e_fall;
    assign w_x_req = (r_xstate == X_OPEN) && w_x_fall;

    // ---------------- open-barrier timers ----------------
    logic w_e_to, w_x_to;
`ifdef GATE_TIMEOUT_EN
    localparam int TW = $clog2(OPEN_TIMEOUT + 1);
    logic [TW-1:0] r_etmr;
    logic [TW-1:0] r_xtmr;
    logic          r_to;

    // Timers sit at zero outside the open state, so they start fresh on
    // every opening. Passage in the expiry cycle takes priority.
    assign w_e_to = (r_estate == E_OPEN) && !w_e_fall && (r_etmr == TW'(OPEN_TIMEOUT - 1));
    assign w_x_to = (r_xstate == X_OPEN) && !w_x_fall && (r_xtmr == TW'(OPEN_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_etmr <= '0;
            r_xtmr <= '0;
            r_to   <= 1'b0;
        end else begin
            r_etmr <= (r_estate == E_OPEN) ? r_etmr + 1'b1 : '0;
            r_xtmr <= (r_xstate == X_OPEN) ? r_xtmr + 1'b1 : '0;
            r_to   <= w_e_to | w_x_to;
        end
    end
    assign o_timeout_err = r_to;
`else
    assign w_e_to        = 1'b0;
    assign w_x_to        = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    // ---------------- entry FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estate <= E_IDLE;
            r_euni   <= 1'b0;
            r_denied <= 1'b0;
        end else begin
            r_denied <= 1'b0;
            case (r_estate)
                E_IDLE: if (w_e_rise) begin
                    r_euni   <= i_entry_badge;
                    r_estate <= E_CHECK;
                end
                E_CHECK: if (r_euni ? i_uni_is_vacated_space : i_is_vacated_space) begin
                    r_estate <= E_OPEN;
                end else begin
                    r_estate <= E_DENY;
                    r_denied <= 1'b1;
                end
                E_OPEN: if (w_e_fall) begin
                    r_estate <= E_IDLE;
                end else if (w_e_to) begin
                    // Timed out with the car still on the loop: wait for it to leave.
                    r_estate <= E_DENY;
                end
                E_DENY: if (!w_e_lvl) r_estate <= E_IDLE;
                default: r_estate <= E_IDLE;
            endcase
        end
    end

    // ---------------- exit FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xstate <= X_IDLE;
            r_xuni   <= 1'b0;
        end else begin
            case (r_xstate)
                X_IDLE: if (w_x_rise) begin
                    r_xuni   <= i_exit_badge;
                    r_xstate <= X_OPEN;
                end
                X_OPEN: if (w_x_fall || w_x_to) r_xstate <= X_IDLE;
                default: r_xstate <= X_IDLE;
            endcase
        end
    end

    // ---------------- event arbitration ----------------
    logic r_ent, r_ent_uni, r_ext, r_ext_uni, r_pend, r_pend_uni;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ent      <= 1'b0;
            r_ent_uni  <= 1'b0;
            r_ext      <= 1'b0;
            r_ext_uni  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_uni <= 1'b0;
        end else begin
            r_ent     <= w_e_req;
            r_ent_uni <= w_e_req & r_euni;
            if (w_e_req) begin
                // Entry owns this slot; park a colliding exit for next cycle.
                r_ext     <= 1'b0;
                r_ext_uni <= 1'b0;
                if (w_x_req) begin
                    r_pend     <= 1'b1;
                    r_pend_uni <= r_xuni;
                end
            end else if (r_pend) begin
                r_ext      <= 1'b1;
                r_ext_uni  <= r_pend_uni;
                r_pend     <= w_x_req;
                r_pend_uni <= r_xuni;
            end else begin
                r_ext     <= w_x_req;
                r_ext_uni <= w_x_req & r_xuni;
            end
        end
    end

    assign o_entry_barrier_open = (r_estate == E_OPEN);
    assign o_exit_barrier_open  = (r_xstate == X_OPEN);
    assign o_car_entered        = r_ent;
    assign o_is_uni_car_entered = r_ent_uni;
    assign o_car_exited         = r_ext;
    assign o_is_uni_car_exited  = r_ext_uni;
    assign o_entry_denied       = r_denied;
endmodule
